data_memory: RTL and testbench
==============================

// Module: data_memory
// PURPOSE
//  Byte-addressed, little-endian data RAM for the 5-stage RV32I pipeline, sitting in the memory stage.
//  - Reads are combinational; writes are synchronous.
//  - Supports byte, halfword and word access, taken from funct3[1:0].
//  - Load results are sign- or zero-extended per SIGNED (= !funct3[2]).
//  - DATA_OUT is valid in the same cycle as ADDR, so the memory stage can capture it at the next edge.
// PARAMETERS
//  ADDR_W  12  byte-address bits actually decoded; capacity = 2**ADDR_W bytes (default 4 KiB)
// PORTS
//  CLK        in   1   clock; all state changes on posedge
//  RST        in   1   reset, synchronous, active-high
//  WE         in   1   write enable (store instruction in memory stage)
//  ADDR       in   32  byte address; only ADDR[ADDR_W-1:0] used, upper bits ignored
//  DATA_IN    in   32  store data; low 8/16/32 bits used per DATA_SIZE
//  DATA_SIZE  in   2   0=byte, 1=half, 2=word, 3=reserved
//  SIGNED     in   1   1=sign-extend load result, 0=zero-extend
//  DATA_OUT   out  32  load result, combinational
//  MISALIGN   out  1   only when DMEM_MISALIGN_CHK_EN defined
// BEHAVIOUR
//  - Storage: 2**ADDR_W bytes.
//    - Byte at address a holds bits [8k+7:8k] of a multi-byte value starting at a-k (little-endian).
//  - Reset: on posedge CLK with RST=1, every byte is cleared to 0x00 and any write in that cycle is dropped.
//    - After reset DATA_OUT = 0 for every address and size.
//  - Write: on posedge CLK with RST=0, WE=1.
//    - Size 0 writes DATA_IN[7:0] to a.
//    - Size 1 writes DATA_IN[15:0] to a, a+1.
//    - Size 2 writes DATA_IN[31:0] to a..a+3.
//    - Size 3 writes nothing.
//    - New data is visible on DATA_OUT from the cycle after the edge.
//  - Read: combinational, every cycle regardless of WE.
//    - Size 0: {24{SIGNED & b7}, byte}.
//    - Size 1: {16{SIGNED & b15}, half}.
//    - Size 2: full word; SIGNED is ignored.
//    - Size 3: 0.
//  - Same-cycle read and write to the same address: DATA_OUT shows the old contents until the edge (no bypass).
//  - Misaligned access (half at odd address, word at address not divisible by 4) without the macro:
//    - The access is performed byte-wise at consecutive addresses.
//  - Address wrap: byte addresses are computed modulo 2**ADDR_W.
//    - Example: a word at 0xFFE with ADDR_W=12 uses bytes 0xFFE, 0xFFF, 0x000, 0x001.
//  - No latency beyond the above; no handshake; always ready.
// CONFIGURATION
//  DMEM_MISALIGN_CHK_EN
//  - Defined:
//    - Adds output MISALIGN, asserted combinationally when (DATA_SIZE==1 && ADDR[0]) or (DATA_SIZE==2 && ADDR[1:0]!=0).
//    - While MISALIGN=1, writes are suppressed and DATA_OUT = 0.
//    - MISALIGN = 0 during and after reset when the inputs are aligned.
//  - Undefined:
//    - No MISALIGN port; misaligned accesses behave byte-wise as above.
// STRUCTURE
//  - Shared package dmem_pkg:
//    - localparams SZ_BYTE=2'd0, SZ_HALF=2'd1, SZ_WORD=2'd2, SZ_RSVD=2'd3.
//    - 2-bit typedef dmem_size_t.
//  - Sub-module dmem_load_ext: combinational; takes 4 raw bytes, size and SIGNED, produces the 32-bit extended result.
//  - Top module holds the byte array, write-lane enables, address wrap and the optional misalign check.
// TESTING
//  1. RST=1 one edge, then read word@0x100 -> DATA_OUT=0x00000000.
//  2. Store word 0x8899AABB @0x010.
//     - Read word -> 0x8899AABB.
//     - Read byte@0x010 SIGNED=1 -> 0xFFFFFFBB; SIGNED=0 -> 0x000000BB.
//     - Read half@0x012 SIGNED=1 -> 0xFFFF8899; SIGNED=0 -> 0x00008899.
//  3. Store byte 0x7F @0x011 over the step-2 word -> word@0x010 reads 0x88997FBB; other bytes unchanged.
//  4. Same-cycle store word 0x12345678 @0x020 while reading @0x020.
//     - DATA_OUT = old value (0) before the edge, 0x12345678 after it.
//  5. Size 3 store of 0xDEADBEEF @0x030 -> word@0x030 still 0; size 3 read -> 0.
//  6. Word store 0xCAFEF00D @0xFFE (ADDR_W=12).
//     - Bytes 0xFFE=0x0D, 0xFFF=0xF0, 0x000=0xFE, 0x001=0xCA.
//     - With DMEM_MISALIGN_CHK_EN: MISALIGN=1 and memory unchanged.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data memory.
// Size codes and store lane masks.
package dmem_pkg;

  typedef logic [1:0] dmem_size_t;

  localparam dmem_size_t SZ_BYTE = 2'd0;
  localparam dmem_size_t SZ_HALF = 2'd1;
  localparam dmem_size_t SZ_WORD = 2'd2;
  localparam dmem_size_t SZ_RSVD = 2'd3;

  function automatic logic [3:0] lane_mask(
    input dmem_size_t sz
  );
    logic [3:0] m;
    m = 4'b0000;
    unique case (1'b1)
      sz == SZ_BYTE: m = 4'b0001;
      sz == SZ_HALF: m = 4'b0011;
      sz == SZ_WORD: m = 4'b1111;
      sz == SZ_RSVD: m = 4'b0000;
      default:       m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// Load result formatter for the data memory.
// Picks byte/half/word from four raw bytes and extends it.
module dmem_load_ext
  import dmem_pkg::*;
(
  input  logic [31:0] raw,
  input  dmem_size_t  size,
  input  logic        sign_ext,
  output logic [31:0] data
);

  logic b7;
  logic b15;

  assign b7  = sign_ext & raw[7];
  assign b15 = sign_ext & raw[15];

  always_comb begin
    data = 32'h0;
    unique case (1'b1)
      size == SZ_BYTE: data = {{24{b7}}, raw[7:0]};
      size == SZ_HALF: data = {{16{b15}}, raw[15:0]};
      size == SZ_WORD: data = raw;
      size == SZ_RSVD: data = 32'h0;
      default:         data = 32'h0;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// Byte-addressed little-endian data RAM for the memory stage.
// Optional misalign check: define DMEM_MISALIGN_CHK_EN.
module data_memory
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        WE,
  input  logic [31:0] ADDR,
  input  logic [31:0] DATA_IN,
  input  logic [1:0]  DATA_SIZE,
  input  logic        SIGNED,
`ifdef DMEM_MISALIGN_CHK_EN
  output logic        MISALIGN,
`endif
  output logic [31:0] DATA_OUT
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] baddr [4];
  logic [3:0]        lane;
  logic [31:0]       raw;
  logic [31:0]       ext;
  logic              mis;
  logic              addr_unused;

  assign addr_unused = ^ADDR[31:ADDR_W];

`ifdef DMEM_MISALIGN_CHK_EN
  assign mis = (DATA_SIZE == SZ_HALF && ADDR[0])
            || (DATA_SIZE == SZ_WORD && ADDR[1:0] != 2'b00);
  assign MISALIGN = mis;
`else
  assign mis = 1'b0;
`endif

  // Lane addresses wrap naturally in ADDR_W bits.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      baddr[k] = ADDR[ADDR_W-1:0] + ADDR_W'(k);
    end
  end

  assign lane = lane_mask(dmem_size_t'(DATA_SIZE));

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (WE && !mis) begin
      for (int k = 0; k < 4; k++) begin
        if (lane[k]) begin
          mem[baddr[k]] <= DATA_IN[8*k +: 8];
        end
      end
    end
  end

  always_comb begin
    raw = 32'h0;
    for (int k = 0; k < 4; k++) begin
      raw[8*k +: 8] = mem[baddr[k]];
    end
  end

  dmem_load_ext u_ext (
    .raw      (raw),
    .size     (dmem_size_t'(DATA_SIZE)),
    .sign_ext (SIGNED),
    .data     (ext)
  );

  assign DATA_OUT = mis ? 32'h0 : ext;

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory with a byte-array reference.
// Stimulus pushes expected reads; a negedge monitor pops and compares.
module tb_data_memory;

  logic        CLK;
  logic        RST;
  logic        WE;
  logic [31:0] ADDR;
  logic [31:0] DATA_IN;
  logic [1:0]  DATA_SIZE;
  logic        SIGNED;
  logic [31:0] DATA_OUT;
  logic        mis_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       nm;
    logic [31:0] data;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  logic [7:0] ref_mem [4096];

  data_memory #(.ADDR_W(12)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .WE        (WE),
    .ADDR      (ADDR),
    .DATA_IN   (DATA_IN),
    .DATA_SIZE (DATA_SIZE),
    .SIGNED    (SIGNED),
`ifdef DMEM_MISALIGN_CHK_EN
    .MISALIGN  (mis_out),
`endif
    .DATA_OUT  (DATA_OUT)
  );

`ifndef DMEM_MISALIGN_CHK_EN
  assign mis_out = 1'b0;
`endif

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic bit ref_mis(int a, int sz);
`ifdef DMEM_MISALIGN_CHK_EN
    return (sz == 1 && (a % 2) != 0) || (sz == 2 && (a % 4) != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int nbytes(int sz);
    if (sz == 0) return 1;
    if (sz == 1) return 2;
    if (sz == 2) return 4;
    return 0;
  endfunction

  function automatic logic [31:0] ref_read(int a, int sz, bit sg);
    longint v;
    int n;
    v = 0;
    if (ref_mis(a, sz)) return 32'h0;
    n = nbytes(sz);
    for (int i = 0; i < n; i++) begin
      v += longint'(ref_mem[(a + i) % 4096]) << (8 * i);
    end
    if (sg && n > 0 && n < 4 && v >= (longint'(1) << (8 * n - 1))) begin
      v -= longint'(1) << (8 * n);
    end
    return v[31:0];
  endfunction

  task automatic step(input bit rst, input bit we,
                      input logic [31:0] addr,
                      input logic [31:0] din,
                      input int sz, input bit sg,
                      input string nm);
    exp_t e;
    int a;
    logic [31:0] dv;
    @(posedge CLK);
    #1;
    RST       = rst;
    WE        = we;
    ADDR      = addr;
    DATA_IN   = din;
    DATA_SIZE = 2'(sz);
    SIGNED    = sg;
    a = int'(addr & 32'hFFF);
    if (!rst) begin
      e.nm   = nm;
      e.data = ref_read(a, sz, sg);
      e.mis  = ref_mis(a, sz);
      exp_q.push_back(e);
    end
    if (rst) begin
      for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
    end else if (we && !ref_mis(a, sz)) begin
      dv = din;
      for (int i = 0; i < nbytes(sz); i++) begin
        ref_mem[(a + i) % 4096] = dv[7:0];
        dv = dv >> 8;
      end
    end
  endtask

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (DATA_OUT !== e.data) begin
        errors++;
        $display("FAIL %s data got %08h want %08h",
                 e.nm, DATA_OUT, e.data);
      end
      checks++;
      if (mis_out !== e.mis) begin
        errors++;
        $display("FAIL %s misalign got %0b want %0b",
                 e.nm, mis_out, e.mis);
      end
    end
  end

  initial begin
    logic [31:0] ra;
    int lo;
    RST = 1'b1;
    WE = 1'b0;
    ADDR = 32'h0;
    DATA_IN = 32'h0;
    DATA_SIZE = 2'd2;
    SIGNED = 1'b0;

    step(1, 1, 32'h100, 32'hFFFFFFFF, 2, 0, "rst");
    step(1, 0, 32'h100, 32'h0, 2, 0, "rst");
    step(0, 0, 32'h100, 32'h0, 2, 0, "reset_word");
    step(0, 0, 32'h010, 32'h0, 0, 1, "reset_byte");

    step(0, 1, 32'h010, 32'h8899AABB, 2, 0, "st_word");
    step(0, 0, 32'h010, 32'h0, 2, 0, "ld_word");
    step(0, 0, 32'h010, 32'h0, 0, 1, "ld_byte_s");
    step(0, 0, 32'h010, 32'h0, 0, 0, "ld_byte_u");
    step(0, 0, 32'h012, 32'h0, 1, 1, "ld_half_s");
    step(0, 0, 32'h012, 32'h0, 1, 0, "ld_half_u");

    step(0, 1, 32'h011, 32'h0000007F, 0, 0, "st_byte");
    step(0, 0, 32'h010, 32'h0, 2, 0, "ld_after_byte");

    step(0, 1, 32'h020, 32'h12345678, 2, 0, "same_cyc_old");
    step(0, 0, 32'h020, 32'h0, 2, 0, "same_cyc_new");

    step(0, 1, 32'h030, 32'hDEADBEEF, 3, 0, "rsvd_st");
    step(0, 0, 32'h030, 32'h0, 2, 0, "rsvd_word");
    step(0, 0, 32'h010, 32'h0, 3, 1, "rsvd_ld");

    step(0, 1, 32'hFFE, 32'hCAFEF00D, 2, 0, "wrap_st");
    step(0, 0, 32'hFFE, 32'h0, 0, 0, "wrap_b0");
    step(0, 0, 32'hFFF, 32'h0, 0, 0, "wrap_b1");
    step(0, 0, 32'h000, 32'h0, 0, 0, "wrap_b2");
    step(0, 0, 32'h001, 32'h0, 0, 0, "wrap_b3");
    step(0, 0, 32'hFFE, 32'h0, 2, 1, "wrap_word");

    step(0, 1, 32'h011, 32'h0000BEEF, 1, 0, "mis_half_st");
    step(0, 0, 32'h010, 32'h0, 2, 0, "mis_half_ld");
    step(0, 0, 32'hABC00010, 32'h0, 2, 0, "upper_ignored");

    for (int i = 0; i < 600; i++) begin
      lo = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 63))
                                       : int'($urandom_range(4080, 4095));
      ra = ($urandom() & 32'hFFFFF000) | 32'(lo);
      if (i == 300) begin
        step(1, 1, ra, $urandom(), 2, 0, "rst");
      end else begin
        step(0, $urandom_range(0, 1) == 1, ra, $urandom(),
             int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
             "rand");
      end
    end

    repeat (4) @(posedge CLK);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
